// File: rtl/key_scan.sv
// key_scan: keypad front end for the 4x3 matrix keypad.
// Scans the active-low column lines, samples the active-low row lines through
// a 2-FF synchronizer, debounces presses and releases, and emits a one-cycle
// key_valid pulse with a 4-bit key code for every accepted press.
//
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous active-low reset
//   row[3:0]  - keypad row lines, active-low, asynchronous to clock
//   col[2:0]  - keypad column drive, active-low one-hot
//   key_code  - code of the last accepted key, held until the next accept
//   key_valid - one-cycle pulse when a press is accepted
//   key_held  - high from accept until the release is accepted
module key_scan #(
    parameter int unsigned SCAN_CYCLES     = 250,
    parameter int unsigned DEBOUNCE_CYCLES = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned SCW = $clog2(SCAN_CYCLES + 1);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_CYCLES - 1);
    localparam logic [SCW-1:0] DETECT_MIN = SCW'(3);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_PRE    = DBW'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     row_meta_q, row_meta_d;
    logic [3:0]     row_s_q, row_s_d;
    logic [2:0]     col_q, col_d;
    logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
    logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]     row_lat_q, row_lat_d;
    logic [1:0]     col_lat_q, col_lat_d;
    logic [3:0]     key_code_q, key_code_d;
    logic           key_valid_q, key_valid_d;
    logic           key_held_q, key_held_d;

    logic [1:0]     col_idx;
    logic [1:0]     row_idx;
    logic [3:0]     key_dec;
    logic [2:0]     col_rot;
    logic [DBW-1:0] deb_inc;

    // Index of the column currently driven low
    always_comb begin
        if (!col_q[0])      col_idx = 2'd0;
        else if (!col_q[1]) col_idx = 2'd1;
        else                col_idx = 2'd2;
    end

    // Lowest-index low row wins when several rows are low
    always_comb begin
        if (!row_lat_q[0])      row_idx = 2'd0;
        else if (!row_lat_q[1]) row_idx = 2'd1;
        else if (!row_lat_q[2]) row_idx = 2'd2;
        else                    row_idx = 2'd3;
    end

    always_comb begin
        key_dec = '0;
        if (row_idx == 2'd3) begin
            case (col_lat_q)
                2'd0:    key_dec = 4'hA;
                2'd1:    key_dec = 4'h0;
                default: key_dec = 4'hB;
            endcase
        end else begin
            key_dec = 4'({2'b00, row_idx} * 4'd3 + {2'b00, col_lat_q} + 4'd1);
        end
    end

    assign col_rot = {col_q[1:0], col_q[2]};
    assign deb_inc = (deb_cnt_q == DEB_LAST) ? deb_cnt_q : deb_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        row_meta_d  = row;
        row_s_d     = row_meta_q;
        col_d       = col_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        row_lat_d   = row_lat_q;
        col_lat_d   = col_lat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            ST_SCAN: begin
                if (scan_cnt_q >= DETECT_MIN && row_s_q != 4'hF) begin
                    // Detection takes priority over rotation so the latched
                    // column index matches the frozen column.
                    row_lat_d = row_s_q;
                    col_lat_d = col_idx;
                    deb_cnt_d = '0;
                    state_d   = ST_DEBOUNCE;
                end else if (scan_cnt_q >= SCAN_LAST) begin
                    col_d      = col_rot;
                    scan_cnt_d = '0;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end

            ST_DEBOUNCE: begin
                if (row_s_q == 4'hF) begin
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    state_d    = ST_SCAN;
                end else if (row_s_q != row_lat_q) begin
                    row_lat_d = row_s_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_inc;
                    // The detect cycle was already one stable cycle, so the
                    // accept fires as the counter steps onto its last value.
                    if (deb_cnt_q == DEB_PRE) begin
                        state_d = ST_PRESSED;
                    end
                end
            end

            ST_PRESSED: begin
                key_code_d  = key_dec;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
                deb_cnt_d   = '0;
                state_d     = ST_RELEASE;
            end

            ST_RELEASE: begin
                if (row_s_q != 4'hF) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    key_held_d = 1'b0;
                    deb_cnt_d  = '0;
                    col_d      = col_rot;
                    scan_cnt_d = '0;
                    state_d    = ST_SCAN;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end

            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SCAN;
            row_meta_q  <= 4'hF;
            row_s_q     <= 4'hF;
            col_q       <= 3'b110;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            row_lat_q   <= 4'hF;
            col_lat_q   <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_meta_q  <= row_meta_d;
            row_s_q     <= row_s_d;
            col_q       <= col_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            row_lat_q   <= row_lat_d;
            col_lat_q   <= col_lat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: self-checking bench for key_scan.
// A behavioural keypad (contact matrix shorting row r to column c when the
// column is driven low) is driven with randomized bouncy presses; expected
// codes come from the key map and latencies from the timing rules.
module tb_key_scan;

    localparam int unsigned SCAN      = 250;
    localparam int unsigned DEB       = 500;
    localparam int unsigned PRESS_MIN = DEB + 3;
    localparam int unsigned PRESS_MAX = 2 * SCAN + 3 + DEB + 3;
    localparam int unsigned HOLD      = 1050;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [11:0] contact;
    logic [3:0]  force_n;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;

    // Key index k = row*3 + col
    logic [3:0] keymap [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

    always #10 clock = ~clock;

    key_scan #(
        .SCAN_CYCLES    (SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Physical keypad: a closed contact pulls its row low while its column is driven
    always_comb begin
        row = force_n;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (contact[r*3 + c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    // Counts every cycle key_valid is high, so a wide pulse shows as extra
    always @(negedge clock) begin
        if (key_valid) n_valid++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #5;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bounce(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            contact[k] = ~contact[k];
            ticks(int'($urandom_range(1, 50)));
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!key_valid && lat < int'(PRESS_MAX) + 20);
    endtask

    task automatic wait_release(output int lat);
        lat = 0;
        while (key_held && lat < int'(DEB) + 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_press(input int ka, input int kb, input int nb,
                            input logic [3:0] exp_code, input string name);
        int n0;
        int lat;
        n0 = n_valid;
        bounce(ka, nb);
        contact[ka] = 1'b1;
        if (kb >= 0) contact[kb] = 1'b1;
        wait_valid(lat);
        check_val($sformatf("%s_press_lat(%0d)", name, lat),
                  32'(lat >= int'(PRESS_MIN) && lat <= int'(PRESS_MAX)), 32'd1);
        check_val({name, "_code"}, 32'(key_code), 32'(exp_code));
        check_val({name, "_held_at_valid"}, 32'(key_held), 32'd1);
        if (lat < int'(HOLD)) ticks(int'(HOLD) - lat);
        check_val({name, "_held_during_hold"}, 32'(key_held), 32'd1);
        bounce(ka, nb);
        contact[ka] = 1'b0;
        if (kb >= 0) contact[kb] = 1'b0;
        wait_release(lat);
        check_val({name, "_release_lat"}, 32'(lat), 32'(DEB + 2));
        check_val({name, "_valid_count"}, 32'(n_valid - n0), 32'd1);
        check_val({name, "_code_stable"}, 32'(key_code), 32'(exp_code));
        ticks(50);
    endtask

    initial begin
        #(90000 * 20);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        int c;
        int n0;
        logic [2:0] prev;
        logic [2:0] exp_col [3];
        logic found;

        reset   = 1'b0;
        contact = '0;
        force_n = 4'hF;
        #200;
        check_val("rst_col", 32'(col), 32'(3'b110));
        check_val("rst_code", 32'(key_code), 32'h0);
        check_val("rst_valid", 32'(key_valid), 32'h0);
        check_val("rst_held", 32'(key_held), 32'h0);
        reset = 1'b1;

        // Column rotation timing after reset
        exp_col[0] = 3'b101;
        exp_col[1] = 3'b011;
        exp_col[2] = 3'b110;
        for (int s = 0; s < 3; s++) begin
            prev = col;
            lat  = 0;
            while (col == prev && lat < int'(SCAN) + 10) begin
                tick();
                lat++;
            end
            check_val($sformatf("scan_step%0d_len", s), 32'(lat), 32'(SCAN));
            check_val($sformatf("scan_step%0d_col", s), 32'(col), 32'(exp_col[s]));
        end

        // Glitch rejection: row[2] low for 400 cycles
        n0 = n_valid;
        force_n[2] = 1'b0;
        ticks(400);
        force_n[2] = 1'b1;
        ticks(600);
        check_val("glitch_no_valid", 32'(n_valid - n0), 32'd0);
        check_val("glitch_held", 32'(key_held), 32'd0);
        prev = col;
        lat  = 0;
        while (col == prev && lat < int'(SCAN) + 10) begin
            tick();
            lat++;
        end
        check_val("glitch_col_unfrozen", 32'(col != prev), 32'd1);

        // Back-to-back randomized bouncy presses (includes key 4 explicitly)
        do_press(3, -1, 30, keymap[3], "key4");
        for (int i = 0; i < 6; i++) begin
            k = int'($urandom_range(0, 11));
            do_press(k, -1, 30, keymap[k], $sformatf("rand%0d_k%0d", i, k));
        end

        // Two rows low on col0: row0 (key 1) wins over row3 (key *)
        do_press(0, 9, 0, 4'h1, "two_rows");

        // Reset asserted mid-debounce with the key held
        k = int'($urandom_range(0, 11));
        c = k % 3;
        prev  = col;
        found = 1'b0;
        for (int i = 0; i < int'(3 * SCAN) + 10 && !found; i++) begin
            tick();
            if (prev[c] && !col[c]) found = 1'b1;
            prev = col;
        end
        check_val("rstmid_col_found", 32'(found), 32'd1);
        contact[k] = 1'b1;
        ticks(205);
        n0 = n_valid;
        reset = 1'b0;
        #1;
        check_val("rstmid_col", 32'(col), 32'(3'b110));
        check_val("rstmid_code", 32'(key_code), 32'h0);
        check_val("rstmid_valid", 32'(key_valid), 32'h0);
        check_val("rstmid_held", 32'(key_held), 32'h0);
        ticks(10);
        reset = 1'b1;
        check_val("rstmid_no_valid", 32'(n_valid - n0), 32'd0);
        wait_valid(lat);
        check_val($sformatf("rstmid_press_lat(%0d)", lat),
                  32'(lat >= int'(PRESS_MIN) && lat <= int'(PRESS_MAX)), 32'd1);
        check_val("rstmid_code_after", 32'(key_code), 32'(keymap[k]));
        contact[k] = 1'b0;
        wait_release(lat);
        check_val("rstmid_release_lat", 32'(lat), 32'(DEB + 2));
        check_val("rstmid_valid_count", 32'(n_valid - n0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_scan.md
# key_scan

Keypad front end for the lock: drives the three active-low column lines of the 4×3 matrix keypad, samples the four row lines, and rejects contact bounce. It emits one clean `key_valid` pulse with a 4-bit key code per physical press, and releases only after the key has been stably up. Sits between the keypad pins (`row`/`col`) and the lock control FSM in `top_1`.

## Interface
- `SCAN_CYCLES`, 250: clock cycles each column is driven low while scanning (5 µs at 50 MHz).
- `DEBOUNCE_CYCLES`, 500: consecutive stable cycles required to accept a press or a release (10 µs at 50 MHz).
- `clock` input 1: single system clock, 50 MHz, all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `row` input 4: keypad row lines, active-low, asynchronous to `clock`.
- `col` output 3: keypad column drive, active-low one-hot.
- `key_code` output 4: code of the last accepted key; held until the next accept.
- `key_valid` output 1: one-cycle pulse when a press is accepted.
- `key_held` output 1: high from accept until the release is accepted.

## Operation
- `row` passes through a 2-FF synchronizer (`row_s`) before any use. Synchronizer flops reset to 4'b1111.
- Key map (row r, col c, with col0 = `col[0]` low):
  - r0 → 1, 2, 3
  - r1 → 4, 5, 6
  - r2 → 7, 8, 9
  - r3 → `*`=4'hA, 0=4'h0, `#`=4'hB
- If several rows are low at once, the lowest-index low row wins.
- States:
  - SCAN: `col` rotates 110 → 101 → 011 → 110 every `SCAN_CYCLES` cycles. Detection is enabled only when the in-column counter is ≥ 3, which masks synchronizer lag after a column change. If `row_s` != 1111 with detection enabled: latch `row_s` and the column index, clear the debounce counter, go to DEBOUNCE.
  - DEBOUNCE: `col` is frozen.
    - `row_s` == 1111: clear the counter, return to SCAN on the same column with the scan counter cleared.
    - `row_s` != latched pattern (but not 1111): re-latch and clear the counter.
    - Otherwise increment. When the counter reaches `DEBOUNCE_CYCLES`-1, go to PRESSED.
  - PRESSED: one cycle. `key_code` is loaded, `key_valid` = 1 and `key_held` = 1 on the following edge. Go to RELEASE.
  - RELEASE: `col` stays frozen. Count consecutive cycles with `row_s` == 1111; any low row clears the count. On reaching `DEBOUNCE_CYCLES`-1: clear `key_held`, go to SCAN, and advance to the next column.
- No second `key_valid` while `key_held` = 1, whatever the row activity.
- Debounce counter width: $clog2(`DEBOUNCE_CYCLES`+1). Scan counter width: $clog2(`SCAN_CYCLES`+1). Both saturate at terminal count and never wrap.

## Timing
- Reset values (asynchronous on `reset` low):
  - state SCAN, `col` = 3'b110
  - `key_code` = 4'h0, `key_valid` = 0, `key_held` = 0
  - all counters 0
- Reset asserted mid-press aborts with no `key_valid`. After reset is released, a still-held key is re-detected from SCAN and accepted normally.
- Press latency from the last bounce edge on `row` to `key_valid`: at most 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles, once the matching column is being driven.
- Worst-case added scan wait before detection: 2·`SCAN_CYCLES` + 3 cycles.
- Release latency from the last bounce edge to `key_held` falling: 2 + `DEBOUNCE_CYCLES` cycles.
- `key_valid` is exactly one cycle wide. `key_code` is valid in that cycle and is stable until the next accept.
- Any bounce shorter than `DEBOUNCE_CYCLES` produces no output change.

## Test plan
- Reset: `reset` low for 200 ns, `row` = 1111 → `col` = 110, all outputs 0. After release, `col` steps 101 after 250 cycles, then 011, then back to 110.
- Bouncy press of key 4: row[1] toggled 30 times with random 0–1022 ns gaps, then held at 4'b1101 for 21 µs, then bounced and released → exactly one `key_valid` with `key_code` = 4'h4 (a column matching `col[0]`), `key_held` high about 10 µs after bounce settles, low about 10 µs after release settles.
- Four back-to-back bouncy presses with 1 µs gaps → exactly four `key_valid` pulses and no extra pulses during release bounce.
- Glitch rejection: row[2] low for 400 cycles, then high → no `key_valid`, FSM returns to SCAN with `col` unfrozen.
- Two rows low at once (`row` = 4'b0110 while col0 is driven) → `key_code` = 4'h1 (row0 wins).
- Reset asserted 200 cycles into DEBOUNCE → no `key_valid`, outputs at reset values. After release with the key still held, one `key_valid` with the correct code.
